// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg
// Shared definitions for the FIFO-to-UART drain stage: FSM state
// encodings, UART 8N1 frame constants and the word-to-byte helper.
// No ports (package).
package fifo_uart_tx_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Number of UART bytes carried by one popped FIFO word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / DATA_BITS;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Bit-period timer for the UART transmitter. While run is high it counts
// 0..CLKS_PER_BIT-1 and pulses tick on the terminal count; pre_tick marks
// the cycle just before tick so a registered output can line up with the
// last cycle of a bit. The counter is held at zero while run is low, so
// every bit sequence starts with a full-length first bit.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   run       in   enable counting; low clears the counter
//   tick      out  one-cycle pulse every CLKS_PER_BIT cycles while run=1
//   pre_tick  out  high the cycle before tick
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] baud_cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tick     = run && (baud_cnt == CNT_LAST);
  assign pre_tick = run && (baud_cnt == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drain stage between a synchronous FIFO read port and a UART TX pin.
// Pops one DATA_WIDTH word per transaction and sends it as DATA_WIDTH/8
// 8N1 frames, least-significant byte first, LSB first within each byte.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   en          in   pop enable, only honoured while idle
//   fifo_empty  in   FIFO EMPTY flag
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     out  one-cycle pop strobe
//   tx          out  serial line, idles high
//   busy        out  high from pop strobe until the last stop bit ends
//   word_done   out  pulse on the last cycle of the word's final stop bit
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done
);

  localparam int BPW        = bytes_per_word(DATA_WIDTH);
  localparam int BYTE_CNT_W = $clog2(BPW) + 1;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BPW - 1);
  localparam logic [2:0]            LAST_BIT  = 3'(DATA_BITS - 1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("fifo_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1) begin : g_bad_stop
    $error("fifo_uart_tx: only one stop bit is supported");
  end

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift;
  logic [2:0]            bit_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  run;
  logic                  tick;
  logic                  pre_tick;

  // The bit timer only runs while a frame is on the wire, so it restarts
  // from zero at every start bit of a fresh word.
  assign run = (state == S_START) || (state == S_DATA) || (state == S_STOP);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // Main FSM. tx is registered and loaded with the next bit value on the
  // edge that ends the current bit. The whole word is shifted right as one
  // register, so after eight data bits shift[0] is already the LSB of the
  // next byte. A reset drops the in-flight word; nothing is re-popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tx        <= IDLE_LEVEL;
      fifo_rd   <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      // Set one cycle early so the pulse coincides with the final stop
      // cycle rather than the first idle cycle.
      word_done <= (state == S_STOP) && (byte_cnt == LAST_BYTE) && pre_tick;

      case (state)
        S_IDLE: begin
          tx <= IDLE_LEVEL;
          if (en && !fifo_empty) begin
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
            state   <= S_POP;
          end
        end
        S_POP: begin
          fifo_rd <= 1'b0;
          state   <= S_LOAD;
        end
        S_LOAD: begin
          shift    <= fifo_dout;
          byte_cnt <= '0;
          tx       <= 1'b0;
          state    <= S_START;
        end
        S_START: begin
          if (tick) begin
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (bit_cnt == LAST_BIT) begin
              tx    <= IDLE_LEVEL;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift[1];
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (byte_cnt < LAST_BYTE) begin
              byte_cnt <= byte_cnt + 1'b1;
              tx       <= 1'b0;
              state    <= S_START;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          tx      <= IDLE_LEVEL;
          fifo_rd <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Directed/randomized bench for fifo_uart_tx with a small FIFO model and
// an 8N1 bit-stream reference computed from the popped word.
module tb_fifo_uart_tx;

  localparam int DW    = 32;
  localparam int CPB   = 4;
  localparam int BPW   = DW / 8;
  localparam int NBITS = BPW * 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd;
  logic          tx;
  logic          busy;
  logic          word_done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] words[$];
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .word_done (word_done)
  );

  // FIFO model: EMPTY and Dout both update on the popping edge.
  assign fifo_empty = (rd_cnt >= wr_cnt);

  always @(posedge clk) begin
    if (fifo_rd) begin
      pop_cnt <= pop_cnt + 1;
      if (rd_cnt < wr_cnt) begin
        fifo_dout <= words[rd_cnt];
        rd_cnt    <= rd_cnt + 1;
      end
    end
    if (word_done) done_cnt <= done_cnt + 1;
  end

  // Expected line level for bit-time k of a word: each byte is a
  // start 0, eight data bits LSB first, then a stop 1.
  function automatic logic expBit(input logic [DW-1:0] w, input int k);
    logic [7:0] b;
    int pos;
    b   = 8'(w >> (8 * (k / 10)));
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] w);
    words.push_back(w);
    wr_cnt++;
  endtask

  task automatic waitPop(output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < 300) begin
      @(negedge clk);
      waited++;
      if (fifo_rd) seen = 1'b1;
    end
    if (!seen) checkOutput("pop_timeout", 0, 1);
    else checkOutput("tx_high_at_pop", tx, 1);
  endtask

  // Called on the negedge where fifo_rd was first seen high.
  task automatic checkWord(input logic [DW-1:0] w, input int drop_en_k, input int abort_k);
    bit aborted;
    aborted = 1'b0;
    @(negedge clk);
    checkOutput("rd_one_cycle", fifo_rd, 0);
    checkOutput("tx_high_load", tx, 1);
    checkOutput("busy_load", busy, 1);
    for (int k = 0; k < NBITS; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!aborted) begin
          if (k == abort_k && c == 1) begin
            rst = 1'b1;
            @(negedge clk);
            checkOutput("rst_mid_tx", tx, 1);
            checkOutput("rst_mid_busy", busy, 0);
            checkOutput("rst_mid_done", word_done, 0);
            checkOutput("rst_mid_rd", fifo_rd, 0);
            aborted = 1'b1;
          end else begin
            @(negedge clk);
            if (k == drop_en_k && c == 0) en = 1'b0;
            checkOutput("tx_bit", tx, expBit(w, k));
            checkOutput("word_done", word_done, (k == NBITS - 1 && c == CPB - 1) ? 1 : 0);
            checkOutput("busy_word", busy, 1);
            checkOutput("rd_quiet", fifo_rd, 0);
          end
        end
      end
    end
    if (!aborted) begin
      @(negedge clk);
      checkOutput("busy_end", busy, 0);
      checkOutput("tx_end", tx, 1);
      checkOutput("done_end", word_done, 0);
    end
  endtask

  initial begin
    bit            seen;
    int            waited;
    logic [DW-1:0] wb, wc, wd, we, wf, wg;

    rst = 1'b1;
    en  = 1'b1;
    applyStimulus(32'hA5C30F81);

    // Reset held with data available: outputs stay at rest.
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_rd", fifo_rd, 0);
      checkOutput("rst_busy", busy, 0);
    end
    rst = 1'b0;

    waitPop(seen, waited);
    checkOutput("first_pop_soon", (waited <= 2) ? 1 : 0, 1);
    if (seen) checkWord(32'hA5C30F81, -1, -1);
    checkOutput("pops_a", pop_cnt, 1);
    checkOutput("done_a", done_cnt, 1);

    // Two queued words: three high cycles between them.
    wb = $urandom;
    wc = $urandom;
    applyStimulus(wb);
    applyStimulus(wc);
    waitPop(seen, waited);
    if (seen) checkWord(wb, -1, -1);
    waitPop(seen, waited);
    checkOutput("b2b_gap", waited, 1);
    if (seen) checkWord(wc, -1, -1);
    checkOutput("pops_bc", pop_cnt, 3);
    checkOutput("done_bc", done_cnt, 3);

    // en dropped mid-word: word finishes, no pop until en returns.
    wd = $urandom;
    we = $urandom;
    applyStimulus(wd);
    applyStimulus(we);
    waitPop(seen, waited);
    if (seen) checkWord(wd, 20, -1);
    repeat (20) begin
      @(negedge clk);
      checkOutput("en_low_rd", fifo_rd, 0);
      checkOutput("en_low_busy", busy, 0);
      checkOutput("en_low_tx", tx, 1);
    end
    en = 1'b1;
    @(negedge clk);
    checkOutput("pop_resume", fifo_rd, 1);
    if (fifo_rd) checkWord(we, -1, -1);
    checkOutput("pops_de", pop_cnt, 5);

    // Reset during data bit 3 of byte 1.
    wf = $urandom;
    applyStimulus(wf);
    waitPop(seen, waited);
    if (seen) checkWord(wf, -1, 14);
    @(negedge clk);
    rst = 1'b0;

    // FIFO empty, en high: nothing happens for 100 cycles.
    repeat (100) begin
      @(negedge clk);
      checkOutput("empty_rd", fifo_rd, 0);
      checkOutput("empty_tx", tx, 1);
      checkOutput("empty_busy", busy, 0);
    end
    checkOutput("pops_f", pop_cnt, 6);
    checkOutput("done_f", done_cnt, 5);

    // Normal operation after the reset.
    wg = $urandom;
    applyStimulus(wg);
    waitPop(seen, waited);
    if (seen) checkWord(wg, -1, -1);
    checkOutput("pops_g", pop_cnt, 7);
    checkOutput("done_g", done_cnt, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
